rx_link_ctrl: RTL and testbench

RX_LINK_CTRL -- requirements
Module: rx_link_ctrl

---
 rtl/rx_link_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rx_link_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/rx_link_ctrl.sv
// rtl/rx_link_ctrl.sv - 8b/10b receive link lock/loss controller with elastic-buffer flush
module rx_link_ctrl #(
  parameter int LOCK_COMMAS  = 4,
  parameter int MAX_ERR      = 4,
  parameter int GOOD_RUN     = 4,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic       WordClk,
  input  logic       Rst,
  input  logic       Rx_Enable,
  input  logic       Comma_Detected,
  input  logic       Decode_Error,
  input  logic       Disparity_Error,
  input  logic       Overflow,
  input  logic       Underflow,
  output logic       RX_Valid,
  output logic       Buffer_Flush,
  output logic [2:0] Lock_State,
  output logic [7:0] Loss_Count
);

  localparam int CW = $clog2(LOCK_COMMAS + 1);
  localparam int EW = $clog2(MAX_ERR + 1);
  localparam int GW = $clog2(GOOD_RUN + 1);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  localparam logic [CW-1:0] COMMA_TERM = CW'(LOCK_COMMAS);
  localparam logic [EW-1:0] ERR_TERM   = EW'(MAX_ERR);
  localparam logic [GW-1:0] GOOD_TERM  = GW'(GOOD_RUN);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACQUIRE = 3'd1,
    LOCKED  = 3'd2,
    CHECK   = 3'd3,
    FLUSH   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] comma_cnt, comma_n;
  logic [EW-1:0] err_cnt, err_n;
  logic [GW-1:0] good_cnt, good_n;
  logic [FW-1:0] flush_cnt, flush_n;
  logic          loss_inc;
  logic          word_err;
  logic          buf_err;

  assign word_err = Decode_Error | Disparity_Error;
  assign buf_err  = Overflow | Underflow;

  // State, counter and saturating loss-count registers
  always_ff @(posedge WordClk) begin
    if (Rst) begin
      state      <= IDLE;
      comma_cnt  <= '0;
      err_cnt    <= '0;
      good_cnt   <= '0;
      flush_cnt  <= '0;
      Loss_Count <= '0;
    end else begin
      state     <= state_n;
      comma_cnt <= comma_n;
      err_cnt   <= err_n;
      good_cnt  <= good_n;
      flush_cnt <= flush_n;
      if (loss_inc && (Loss_Count != 8'hFF)) begin
        Loss_Count <= Loss_Count + 8'd1;
      end
    end
  end

  // Next-state and counter update; enable drop beats buffer errors beat word errors beat commas
  always_comb begin
    state_n  = state;
    comma_n  = comma_cnt;
    err_n    = err_cnt;
    good_n   = good_cnt;
    flush_n  = flush_cnt;
    loss_inc = 1'b0;
    if (!Rx_Enable) begin
      state_n = IDLE;
      comma_n = '0;
      err_n   = '0;
      good_n  = '0;
      flush_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ACQUIRE;
          comma_n = '0;
        end
        ACQUIRE: begin
          if (word_err) begin
            comma_n = '0;
          end else if (Comma_Detected) begin
            comma_n = comma_cnt + CW'(1);
            if (comma_cnt + CW'(1) == COMMA_TERM) begin
              state_n = LOCKED;
              err_n   = '0;
              good_n  = '0;
            end
          end
        end
        LOCKED: begin
          if (buf_err) begin
            state_n  = FLUSH;
            flush_n  = '0;
            loss_inc = 1'b1;
          end else if (word_err) begin
            state_n = CHECK;
            err_n   = EW'(1);
            good_n  = '0;
          end
        end
        CHECK: begin
          if (buf_err) begin
            state_n  = FLUSH;
            flush_n  = '0;
            loss_inc = 1'b1;
          end else if (word_err) begin
            err_n  = err_cnt + EW'(1);
            good_n = '0;
            if (err_cnt + EW'(1) == ERR_TERM) begin
              state_n  = ACQUIRE;
              comma_n  = '0;
              loss_inc = 1'b1;
            end
          end else if (good_cnt + GW'(1) == GOOD_TERM) begin
            good_n = '0;
            err_n  = err_cnt - EW'(1);
            if (err_cnt == EW'(1)) begin
              state_n = LOCKED;
            end
          end else begin
            good_n = good_cnt + GW'(1);
          end
        end
        FLUSH: begin
          if (flush_cnt == FLUSH_LAST) begin
            state_n = ACQUIRE;
            comma_n = '0;
          end else begin
            flush_n = flush_cnt + FW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          comma_n = '0;
          err_n   = '0;
          good_n  = '0;
          flush_n = '0;
        end
      endcase
    end
  end

  assign Lock_State   = state;
  assign RX_Valid     = (state == LOCKED) || (state == CHECK);
  assign Buffer_Flush = (state == IDLE) || (state == FLUSH);

endmodule

// File: tb/tb_rx_link_ctrl.sv
// tb/tb_rx_link_ctrl.sv - table-driven bench for rx_link_ctrl
module tb_rx_link_ctrl;

  logic       WordClk = 1'b0;
  logic       Rst = 1'b1;
  logic       Rx_Enable = 1'b0;
  logic       Comma_Detected = 1'b0;
  logic       Decode_Error = 1'b0;
  logic       Disparity_Error = 1'b0;
  logic       Overflow = 1'b0;
  logic       Underflow = 1'b0;
  logic       RX_Valid;
  logic       Buffer_Flush;
  logic [2:0] Lock_State;
  logic [7:0] Loss_Count;

  int passed = 0;
  int total  = 0;

  localparam logic [2:0] S_I = 3'd0, S_A = 3'd1, S_L = 3'd2, S_C = 3'd3, S_F = 3'd4;

  typedef struct {
    logic       rst, en, k, de, dp, ov, un;
    logic [2:0] st;
    logic [7:0] lc;
  } vec_t;

  vec_t vecs[$];

  rx_link_ctrl dut (
    .WordClk(WordClk), .Rst(Rst), .Rx_Enable(Rx_Enable),
    .Comma_Detected(Comma_Detected), .Decode_Error(Decode_Error),
    .Disparity_Error(Disparity_Error), .Overflow(Overflow), .Underflow(Underflow),
    .RX_Valid(RX_Valid), .Buffer_Flush(Buffer_Flush),
    .Lock_State(Lock_State), .Loss_Count(Loss_Count)
  );

  always #5 WordClk = ~WordClk;

  task automatic add(input logic rst, en, k, de, dp, ov, un,
                     input logic [2:0] st, input logic [7:0] lc);
    vec_t v;
    v.rst = rst; v.en = en; v.k = k; v.de = de; v.dp = dp; v.ov = ov; v.un = un;
    v.st = st; v.lc = lc;
    vecs.push_back(v);
  endtask

  task automatic step(input logic rst, en, k, de, dp, ov, un);
    Rst = rst; Rx_Enable = en; Comma_Detected = k;
    Decode_Error = de; Disparity_Error = dp; Overflow = ov; Underflow = un;
    @(posedge WordClk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [7:0] lc);
    check({tag, " state"}, {5'd0, Lock_State}, {5'd0, st});
    check({tag, " rx_valid"}, {7'd0, RX_Valid}, {7'd0, (st == S_L) || (st == S_C)});
    check({tag, " buffer_flush"}, {7'd0, Buffer_Flush}, {7'd0, (st == S_I) || (st == S_F)});
    check({tag, " loss"}, Loss_Count, lc);
  endtask

  initial begin
    //  rst en k de dp ov un  state loss
    add(1, 0, 0, 0, 0, 0, 0, S_I, 0);
    add(0, 0, 1, 0, 0, 0, 0, S_I, 0);
    add(0, 1, 0, 0, 0, 0, 0, S_A, 0);
    add(0, 1, 1, 0, 0, 0, 0, S_A, 0);
    add(0, 1, 1, 0, 0, 0, 0, S_A, 0);
    add(0, 1, 1, 0, 0, 0, 0, S_A, 0);
    add(0, 1, 1, 0, 0, 0, 0, S_L, 0);   // locked after 4th comma
    add(0, 1, 0, 0, 1, 0, 0, S_C, 0);   // err=1
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, S_C, 0);
    add(0, 1, 0, 0, 0, 0, 0, S_L, 0);   // 4 good words -> back to LOCKED
    // errors separated by 3 good words: err climbs 1,2,3 without decrement
    for (int e = 0; e < 3; e++) begin
      add(0, 1, 0, 0, 1, 0, 0, S_C, 0);
      for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, S_C, 0);
    end
    add(0, 1, 0, 0, 0, 0, 0, S_C, 0);   // good run 4 -> err 2
    for (int i = 0; i < 4; i++) add(0, 1, 0, 0, 0, 0, 0, S_C, 0);  // err 1
    for (int i = 0; i < 3; i++) add(0, 1, 0, 0, 0, 0, 0, S_C, 0);
    add(0, 1, 0, 0, 0, 0, 0, S_L, 0);   // err 0
    // four back-to-back errors from LOCKED -> lock loss
    add(0, 1, 0, 0, 1, 0, 0, S_C, 0);
    add(0, 1, 0, 0, 1, 0, 0, S_C, 0);
    add(0, 1, 1, 1, 0, 0, 0, S_C, 0);
    add(0, 1, 0, 0, 1, 0, 0, S_A, 1);
    // ACQUIRE: 3 commas, error, then 4 commas (non-comma and overflow ignored)
    add(0, 1, 1, 0, 0, 0, 0, S_A, 1);
    add(0, 1, 1, 0, 0, 0, 0, S_A, 1);
    add(0, 1, 1, 0, 0, 0, 0, S_A, 1);
    add(0, 1, 1, 1, 0, 0, 0, S_A, 1);   // comma with error clears count
    add(0, 1, 1, 0, 0, 0, 0, S_A, 1);
    add(0, 1, 0, 0, 0, 1, 0, S_A, 1);
    add(0, 1, 1, 0, 0, 0, 0, S_A, 1);
    add(0, 1, 1, 0, 0, 0, 0, S_A, 1);
    add(0, 1, 1, 0, 0, 0, 0, S_L, 1);
    // overflow with decode error -> FLUSH for 8 cycles
    add(0, 1, 0, 1, 0, 1, 0, S_F, 2);
    add(0, 1, 0, 0, 0, 1, 0, S_F, 2);
    add(0, 1, 1, 0, 0, 0, 1, S_F, 2);
    for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 0, 0, S_F, 2);
    add(0, 1, 0, 0, 0, 0, 0, S_A, 2);
    // relock, then Rx_Enable=0 from CHECK and from LOCKED keeps loss count
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 0, S_A, 2);
    add(0, 1, 1, 0, 0, 0, 0, S_L, 2);
    add(0, 1, 0, 0, 1, 0, 0, S_C, 2);
    add(0, 0, 0, 0, 0, 1, 0, S_I, 2);
    add(0, 1, 0, 0, 0, 0, 0, S_A, 2);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 0, S_A, 2);
    add(0, 1, 1, 0, 0, 0, 0, S_L, 2);
    add(0, 0, 1, 0, 0, 0, 0, S_I, 2);
    add(0, 1, 0, 0, 0, 0, 0, S_A, 2);
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, 0, 0, 0, S_A, 2);
    add(0, 1, 1, 0, 0, 0, 0, S_L, 2);
    add(0, 1, 0, 0, 1, 0, 0, S_C, 2);
    add(0, 1, 0, 0, 0, 0, 1, S_F, 3);   // underflow from CHECK
    add(0, 1, 0, 0, 0, 0, 0, S_F, 3);
    add(1, 1, 1, 0, 0, 1, 0, S_I, 0);   // reset mid-flush
    add(0, 1, 0, 0, 0, 0, 0, S_A, 0);

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].rst, vecs[n].en, vecs[n].k, vecs[n].de, vecs[n].dp, vecs[n].ov, vecs[n].un);
      check_all($sformatf("vec%0d", n), vecs[n].st, vecs[n].lc);
    end

    // Loss_Count saturation: repeated lock + overflow cycles
    for (int i = 0; i < 260; i++) begin
      for (int c = 0; c < 4; c++) step(0, 1, 1, 0, 0, 0, 0);
      if (i == 0) check_all("sat_lock", S_L, 0);
      step(0, 1, 0, 0, 0, 1, 0);
      if (i == 253) check_all("sat_254", S_F, 254);
      for (int f = 0; f < 8; f++) step(0, 1, 0, 0, 0, 0, 0);
    end
    check_all("sat_255", S_A, 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
